// File: rtl/trace_pkg.sv
// Shared types for the writeback/store trace buffer: entry layout and halt FSM states.
// Entry fields are sized for the widest supported datapath; narrower instances zero-extend.
package trace_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN_MAX   = 64;
    localparam int CNT_W_MAX  = 64;

    typedef struct packed {
        logic [CNT_W_MAX-1:0]  cycle;
        logic                  has_wb;
        logic                  has_st;
        logic [XLEN_MAX-1:0]   pc;
        logic [REG_ADDR_W-1:0] waddr;
        logic [XLEN_MAX-1:0]   wdata;
        logic [XLEN_MAX-1:0]   st_addr;
        logic [XLEN_MAX-1:0]   st_data;
    } trace_entry_t;

    localparam int ENTRY_W = $bits(trace_entry_t);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port entry storage: synchronous write, asynchronous read for fall-through output.
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_trace_buffer.sv
// Circular trace of retire/store events with cycle stamps, valid/ready drain and
// a retire-count halt request. Supports XLEN and CNT_W up to 64.
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 0,
    parameter int CNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wb_valid,
    input  logic [XLEN-1:0]       wb_pc,
    input  logic [REG_ADDR_W-1:0] wb_waddr,
    input  logic [XLEN-1:0]       wb_wdata,
    input  logic                  st_valid,
    input  logic [XLEN-1:0]       st_addr,
    input  logic [XLEN-1:0]       st_data,
    input  logic [CNT_W-1:0]      halt_at,
    output logic                  trc_valid,
    input  logic                  trc_ready,
    output logic [CNT_W-1:0]      trc_cycle,
    output logic                  trc_has_wb,
    output logic                  trc_has_st,
    output logic [XLEN-1:0]       trc_pc,
    output logic [REG_ADDR_W-1:0] trc_waddr,
    output logic [XLEN-1:0]       trc_wdata,
    output logic [XLEN-1:0]       trc_st_addr,
    output logic [XLEN-1:0]       trc_st_data,
    output logic [$clog2(DEPTH):0] count,
    output logic [CNT_W-1:0]      retired,
    output logic [15:0]           dropped,
    output logic                  halt_req
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] cycle_q, cycle_d, retired_q, retired_d;
    logic [15:0]      dropped_q, dropped_d;
    state_t           state_q, state_d;
    trace_entry_t     wr_entry, rd_entry;
    logic             full, capture, pop, ovf, we, rd_adv, retire, halt_hit;
    logic             unused_rd;

    assign full      = (count_q == DEPTH_C);
    assign trc_valid = (count_q != '0);
    assign pop       = trc_valid && trc_ready && !clear;
    assign capture   = (state_q == RUN) && (wb_valid || st_valid) && !clear;
    assign ovf       = capture && full && !pop;
    // In overwrite mode a full push recycles the head slot, so the read pointer moves with it.
    assign we        = capture && (!ovf || (OVERWRITE != 0));
    assign rd_adv    = pop || (ovf && (OVERWRITE != 0));
    assign retire    = capture && wb_valid;
    assign halt_hit  = retire && (halt_at != '0) && ((retired_q + CNT_W'(1)) == halt_at);

    always_comb begin
        wr_entry       = '0;
        wr_entry.cycle = CNT_W_MAX'(cycle_q);
        if (wb_valid) begin
            wr_entry.has_wb = 1'b1;
            wr_entry.pc     = XLEN_MAX'(wb_pc);
            wr_entry.waddr  = wb_waddr;
            wr_entry.wdata  = XLEN_MAX'(wb_wdata);
        end
        if (st_valid) begin
            wr_entry.has_st  = 1'b1;
            wr_entry.st_addr = XLEN_MAX'(st_addr);
            wr_entry.st_data = XLEN_MAX'(st_data);
        end
    end

    trace_ram #(.DEPTH(DEPTH)) u_ram (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        cycle_d   = cycle_q + CNT_W'(1);
        retired_d = retired_q;
        dropped_d = dropped_q;
        if (we)     wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_adv) rd_ptr_d = rd_ptr_q + AW'(1);
        if (we && !rd_adv)      count_d = count_q + CW'(1);
        else if (!we && rd_adv) count_d = count_q - CW'(1);
        if (retire) retired_d = retired_q + CNT_W'(1);
        if (ovf && (dropped_q != 16'hFFFF)) dropped_d = dropped_q + 16'd1;
        if (clear) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            cycle_d   = '0;
            retired_d = '0;
            dropped_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cycle_q   <= '0;
            retired_q <= '0;
            dropped_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
            dropped_q <= dropped_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (halt_hit) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
        if (clear) state_d = RUN;
    end

    always_comb begin
        halt_req = (state_q == HALT);
    end

    // Payload is forced to zero when empty so an idle stream never shows stale RAM.
    always_comb begin
        trc_cycle   = '0;
        trc_has_wb  = 1'b0;
        trc_has_st  = 1'b0;
        trc_pc      = '0;
        trc_waddr   = '0;
        trc_wdata   = '0;
        trc_st_addr = '0;
        trc_st_data = '0;
        if (trc_valid) begin
            trc_cycle   = rd_entry.cycle[CNT_W-1:0];
            trc_has_wb  = rd_entry.has_wb;
            trc_has_st  = rd_entry.has_st;
            trc_pc      = rd_entry.pc[XLEN-1:0];
            trc_waddr   = rd_entry.waddr;
            trc_wdata   = rd_entry.wdata[XLEN-1:0];
            trc_st_addr = rd_entry.st_addr[XLEN-1:0];
            trc_st_data = rd_entry.st_data[XLEN-1:0];
        end
    end

    assign unused_rd = ^rd_entry;
    assign count     = count_q;
    assign retired   = retired_q;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench driving a drop-newest and an overwrite-oldest buffer (DEPTH=4) side by side.
module tb_wb_trace_buffer;

    typedef struct packed {
        logic [31:0] cycle;
        logic        hasWb;
        logic        hasSt;
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] stAddr;
        logic [31:0] stData;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, clear, wbValid, stValid, trcReady;
    logic [31:0] wbPc, wbWdata, stAddr, stData, haltAt;
    logic [4:0]  wbWaddr;

    logic        trcValid0, trcHasWb0, trcHasSt0, halt0;
    logic [31:0] trcCycle0, trcPc0, trcWdata0, trcStAddr0, trcStData0, retired0;
    logic [4:0]  trcWaddr0;
    logic [2:0]  count0;
    logic [15:0] dropped0;

    logic        trcValid1, trcHasWb1, trcHasSt1, halt1;
    logic [31:0] trcCycle1, trcPc1, trcWdata1, trcStAddr1, trcStData1, retired1;
    logic [4:0]  trcWaddr1;
    logic [2:0]  count1;
    logic [15:0] dropped1;

    exp_t got0, got1;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t ovfEntry[7];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    wb_trace_buffer #(.XLEN(32), .DEPTH(4), .OVERWRITE(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .clear(clear),
        .wb_valid(wbValid), .wb_pc(wbPc), .wb_waddr(wbWaddr), .wb_wdata(wbWdata),
        .st_valid(stValid), .st_addr(stAddr), .st_data(stData), .halt_at(haltAt),
        .trc_valid(trcValid0), .trc_ready(trcReady), .trc_cycle(trcCycle0),
        .trc_has_wb(trcHasWb0), .trc_has_st(trcHasSt0), .trc_pc(trcPc0),
        .trc_waddr(trcWaddr0), .trc_wdata(trcWdata0), .trc_st_addr(trcStAddr0),
        .trc_st_data(trcStData0), .count(count0), .retired(retired0),
        .dropped(dropped0), .halt_req(halt0)
    );

    wb_trace_buffer #(.XLEN(32), .DEPTH(4), .OVERWRITE(1), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst), .clear(clear),
        .wb_valid(wbValid), .wb_pc(wbPc), .wb_waddr(wbWaddr), .wb_wdata(wbWdata),
        .st_valid(stValid), .st_addr(stAddr), .st_data(stData), .halt_at(haltAt),
        .trc_valid(trcValid1), .trc_ready(trcReady), .trc_cycle(trcCycle1),
        .trc_has_wb(trcHasWb1), .trc_has_st(trcHasSt1), .trc_pc(trcPc1),
        .trc_waddr(trcWaddr1), .trc_wdata(trcWdata1), .trc_st_addr(trcStAddr1),
        .trc_st_data(trcStData1), .count(count1), .retired(retired1),
        .dropped(dropped1), .halt_req(halt1)
    );

    assign got0 = {trcCycle0, trcHasWb0, trcHasSt0, trcPc0, trcWaddr0, trcWdata0, trcStAddr0, trcStData0};
    assign got1 = {trcCycle1, trcHasWb1, trcHasSt1, trcPc1, trcWaddr1, trcWdata1, trcStAddr1, trcStData1};

    task automatic checkOutput(input string name, input logic [167:0] got, input logic [167:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic exp_t mkExp(input int c, input logic w, input logic s, input logic [31:0] pc,
                                   input logic [4:0] wa, input logic [31:0] wd,
                                   input logic [31:0] sa, input logic [31:0] sd);
        exp_t e;
        e.cycle  = 32'(c);
        e.hasWb  = w;
        e.hasSt  = s;
        e.pc     = pc;
        e.waddr  = wa;
        e.wdata  = wd;
        e.stAddr = sa;
        e.stData = sd;
        return e;
    endfunction

    task automatic applyStimulus(input logic w, input logic [31:0] pc, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic s,
                                 input logic [31:0] sa, input logic [31:0] sd);
        wbValid = w;
        wbPc    = pc;
        wbWaddr = wa;
        wbWdata = wd;
        stValid = s;
        stAddr  = sa;
        stData  = sd;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic expectBoth(input exp_t e);
        sb0.push_back(e);
        sb1.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Each monitor pops the next expected entry whenever its buffer hands one over.
    always @(negedge clk) begin
        if (trcValid0 && trcReady) begin
            if (sb0.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL mon0_unexpected: got %0h expected none", got0);
            end else begin
                checkOutput("mon0_entry", got0, sb0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (trcValid1 && trcReady) begin
            if (sb1.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL mon1_unexpected: got %0h expected none", got1);
            end else begin
                checkOutput("mon1_entry", got1, sb1.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        trcReady = 1'b0;
        haltAt = 32'd0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        checkOutput("reset_valid0", trcValid0, 0);
        checkOutput("reset_count0", count0, 0);
        checkOutput("reset_retired0", retired0, 0);
        checkOutput("reset_dropped0", dropped0, 0);
        checkOutput("reset_halt0", halt0, 0);
        checkOutput("reset_pc1", trcPc1, 0);

        // Single retire at cycle 3
        trcReady = 1'b1;
        repeat (3) step();
        applyStimulus(1'b1, 32'h8, 5'd3, 32'h6, 1'b0, 32'h0, 32'h0);
        expectBoth(mkExp(3, 1'b1, 1'b0, 32'h8, 5'd3, 32'h6, 32'h0, 32'h0));
        step();
        idle();
        checkOutput("single_valid0", trcValid0, 1);
        step();
        checkOutput("single_count0", count0, 0);
        checkOutput("single_retired0", retired0, 1);

        // Combined writeback and store in one cycle (cycle 5)
        trcReady = 1'b0;
        applyStimulus(1'b1, 32'h10, 5'd4, 32'h2A, 1'b1, 32'h0, 32'h2A);
        expectBoth(mkExp(5, 1'b1, 1'b1, 32'h10, 5'd4, 32'h2A, 32'h0, 32'h2A));
        step();
        idle();
        checkOutput("combined_count0", count0, 1);
        checkOutput("combined_count1", count1, 1);
        trcReady = 1'b1;
        step();
        trcReady = 1'b0;
        checkOutput("combined_drain0", count0, 0);

        // Six stores into a stalled DEPTH=4 buffer
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h100 + 32'(i), 32'(i));
            ovfEntry[i] = mkExp(cyc, 1'b0, 1'b1, 32'h0, 5'd0, 32'h0, 32'h100 + 32'(i), 32'(i));
            step();
        end
        idle();
        for (int i = 1; i <= 4; i++) sb0.push_back(ovfEntry[i]);
        for (int i = 3; i <= 6; i++) sb1.push_back(ovfEntry[i]);
        checkOutput("ovf_count0", count0, 4);
        checkOutput("ovf_dropped0", dropped0, 2);
        checkOutput("ovf_count1", count1, 4);
        checkOutput("ovf_dropped1", dropped1, 2);
        trcReady = 1'b1;
        repeat (4) step();
        trcReady = 1'b0;
        checkOutput("ovf_drain0", count0, 0);
        checkOutput("ovf_drain1", count1, 0);

        clear = 1'b1;
        step();
        clear = 1'b0;
        cyc = 0;
        checkOutput("clear_retired0", retired0, 0);
        checkOutput("clear_dropped0", dropped0, 0);
        checkOutput("clear_dropped1", dropped1, 0);

        // Halt after the fifth retire
        haltAt = 32'd5;
        trcReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 32'h200 + 32'(4 * i), 5'(i + 1), 32'(3 * i + 1), 1'b0, 32'h0, 32'h0);
            if (i < 5) expectBoth(mkExp(cyc, 1'b1, 1'b0, 32'h200 + 32'(4 * i), 5'(i + 1),
                                        32'(3 * i + 1), 32'h0, 32'h0));
            step();
            checkOutput($sformatf("halt_req0_%0d", i), halt0, (i >= 4) ? 1 : 0);
        end
        idle();
        checkOutput("halt_retired0", retired0, 5);
        checkOutput("halt_retired1", retired1, 5);
        step();
        checkOutput("halt_drained0", count0, 0);

        // Clear while halted beats a same-cycle retire
        clear = 1'b1;
        applyStimulus(1'b1, 32'hDEAD, 5'd1, 32'h1, 1'b0, 32'h0, 32'h0);
        step();
        clear = 1'b0;
        idle();
        cyc = 0;
        trcReady = 1'b0;
        checkOutput("hclear_halt0", halt0, 0);
        checkOutput("hclear_halt1", halt1, 0);
        checkOutput("hclear_count0", count0, 0);
        checkOutput("hclear_retired0", retired0, 0);

        applyStimulus(1'b1, 32'h300, 5'd7, 32'h77, 1'b0, 32'h0, 32'h0);
        expectBoth(mkExp(0, 1'b1, 1'b0, 32'h300, 5'd7, 32'h77, 32'h0, 32'h0));
        step();
        checkOutput("resume_count0", count0, 1);
        checkOutput("resume_retired0", retired0, 1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h40 + 32'(i), 32'hA0 + 32'(i));
            step();
        end
        idle();
        checkOutput("pre_rst_count0", count0, 3);

        // Asynchronous reset with three entries pending
        #7;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid0", trcValid0, 0);
        checkOutput("async_rst_valid1", trcValid1, 0);
        checkOutput("async_rst_count0", count0, 0);
        sb0.delete();
        sb1.delete();
        haltAt = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        step();
        trcReady = 1'b1;
        applyStimulus(1'b1, 32'h400, 5'd0, 32'h55, 1'b0, 32'h0, 32'h0);
        expectBoth(mkExp(1, 1'b1, 1'b0, 32'h400, 5'd0, 32'h55, 32'h0, 32'h0));
        step();
        idle();
        checkOutput("post_rst_valid0", trcValid0, 1);
        step();
        checkOutput("post_rst_count0", count0, 0);

        checkOutput("sb0_empty", 168'(sb0.size()), 0);
        checkOutput("sb1_empty", 168'(sb1.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
